// File: rtl/xeng_pkg.sv
// Shared constants and helpers for the X-engine correction-apply block.
// Words are packed {re_xx,re_xy,re_yx,re_yy,im_xx,im_xy,im_yx,im_yy}, re_xx in the top lane.
package xeng_pkg;

  localparam int unsigned N_LANES = 8;

  // Lane index of each word within the 8-word packing (lane 0 = LSBs)
  localparam int unsigned RE_XX = 7;
  localparam int unsigned RE_XY = 6;
  localparam int unsigned RE_YX = 5;
  localparam int unsigned RE_YY = 4;
  localparam int unsigned IM_XX = 3;
  localparam int unsigned IM_XY = 2;
  localparam int unsigned IM_YX = 1;
  localparam int unsigned IM_YY = 0;

  // Lanes that carry real parts and therefore receive the offset constant
  localparam logic [N_LANES-1:0] REAL_LANES =
    N_LANES'((1 << RE_XX) | (1 << RE_XY) | (1 << RE_YX) | (1 << RE_YY));

  // Width of one signed correction word
  function automatic int unsigned corr_width(input int unsigned p_factor_bits,
                                             input int unsigned serial_acc_len_bits,
                                             input int unsigned bitwidth);
    return p_factor_bits + serial_acc_len_bits + bitwidth + 3;
  endfunction

  // Number of X-engine taps for a given antenna count
  function automatic int unsigned n_taps(input int unsigned n_ants);
    return n_ants / 2 + 1;
  endfunction

  // Number of baselines produced per frame
  function automatic int unsigned n_bls(input int unsigned n_ants);
    return n_ants * n_taps(n_ants);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with async reset and synchronous clear.
// A pop on a full FIFO frees a slot for a push in the same cycle; a push on
// an empty FIFO is never bypassed to the read side.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_BITS = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout_c,
  output logic             full_c,
  output logic             empty_c,
  output logic             ovf_c,
  output logic             unf_c
);

  localparam int unsigned DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_BITS:0] wr_ptr;
  logic [DEPTH_BITS:0] rd_ptr;
  logic                do_push_c;
  logic                do_pop_c;

  assign empty_c   = (wr_ptr == rd_ptr);
  assign full_c    = (wr_ptr[DEPTH_BITS] != rd_ptr[DEPTH_BITS]) &&
                     (wr_ptr[DEPTH_BITS-1:0] == rd_ptr[DEPTH_BITS-1:0]);
  assign do_pop_c  = pop && !empty_c && !clr;
  assign do_push_c = push && (!full_c || do_pop_c) && !clr;
  assign ovf_c     = push && full_c && !do_pop_c && !clr;
  assign unf_c     = pop && empty_c && !clr;
  assign dout_c    = mem[rd_ptr[DEPTH_BITS-1:0]];

  // Read/write pointers; clear discards all queued words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + (DEPTH_BITS+1)'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + (DEPTH_BITS+1)'(1);
    end
  end

  // Storage array, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr[DEPTH_BITS-1:0]] <= din;
  end

endmodule

// File: rtl/xeng_corr_apply.sv
// Applies queued offset-binary corrections to raw X-engine accumulations,
// producing signed offset-free correlations with a 2-cycle latency.
// Optional feature: define XENG_CORR_SAT_EN to saturate outputs and add sat_flag.
module xeng_corr_apply
  import xeng_pkg::*;
#(
  parameter int unsigned SERIAL_ACC_LEN_BITS = 7,
  parameter int unsigned P_FACTOR_BITS       = 2,
  parameter int unsigned BITWIDTH            = 4,
  parameter int unsigned N_ANTS              = 32,
  parameter int unsigned XENG_WIDTH          = 24,
  parameter int unsigned FIFO_DEPTH_BITS     = 5,
  localparam int unsigned CORR_W = corr_width(P_FACTOR_BITS, SERIAL_ACC_LEN_BITS, BITWIDTH),
  localparam int unsigned BL_W   = $clog2(n_bls(N_ANTS))
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sync,
  input  logic [N_LANES*CORR_W-1:0]     corr_din,
  input  logic                          corr_vld,
  input  logic [N_LANES*XENG_WIDTH-1:0] xeng_din,
  input  logic                          xeng_vld,
  output logic [N_LANES*XENG_WIDTH-1:0] dout,
  output logic                          dout_vld,
  output logic [BL_W-1:0]               bl_idx,
  output logic                          sync_out,
  output logic                          fifo_ovf,
  output logic                          fifo_unf
`ifdef XENG_CORR_SAT_EN
  ,
  output logic                          sat_flag
`endif
);

  localparam int unsigned N_BLS = n_bls(N_ANTS);
  localparam int unsigned D_W   = XENG_WIDTH + 1;
  localparam int unsigned S_W   = XENG_WIDTH + 2;
  localparam int unsigned K_SH  = SERIAL_ACC_LEN_BITS + P_FACTOR_BITS + 2*BITWIDTH - 2;
  localparam logic signed [S_W-1:0] K_VAL = S_W'(64'd1 << K_SH);

  logic [N_LANES*CORR_W-1:0]     fifo_dout_c;
  logic                          fifo_full_c;
  logic                          fifo_empty_c;
  logic                          fifo_ovf_c;
  logic                          fifo_unf_c;
  logic [N_LANES*CORR_W-1:0]     corr_sel_c;
  logic [N_LANES*D_W-1:0]        d_c;
  logic [N_LANES*XENG_WIDTH-1:0] res_c;

  logic [N_LANES*D_W-1:0]        s1_q;
  logic                          s1_vld;
  logic [BL_W-1:0]               bl_cnt;
  logic                          sync_d;
`ifdef XENG_CORR_SAT_EN
  logic [N_LANES-1:0]            sat_c;
`endif

  // Correction queue; sync acts as a clear and masks the push/pop of its cycle
  sync_fifo_fwft #(
    .WIDTH      (N_LANES*CORR_W),
    .DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (sync),
    .push    (corr_vld),
    .pop     (xeng_vld),
    .din     (corr_din),
    .dout_c  (fifo_dout_c),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c),
    .ovf_c   (fifo_ovf_c),
    .unf_c   (fifo_unf_c)
  );

  // An empty FIFO (or a pop masked by sync) contributes a zero correction
  assign corr_sel_c = (fifo_empty_c || sync) ? '0 : fifo_dout_c;

  // Per-lane arithmetic: stage-1 subtract, stage-2 offset and wrap/saturate
  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    logic signed [XENG_WIDTH-1:0] raw_c;
    logic signed [CORR_W-1:0]     corr_c;
    logic signed [D_W-1:0]        diff_c;
    logic signed [S_W-1:0]        sum_c;

    assign raw_c  = xeng_din[l*XENG_WIDTH +: XENG_WIDTH];
    assign corr_c = corr_sel_c[l*CORR_W +: CORR_W];
    assign diff_c = D_W'(raw_c) - (D_W'(corr_c) <<< (BITWIDTH-1));
    assign d_c[l*D_W +: D_W] = diff_c;
    assign sum_c  = S_W'($signed(s1_q[l*D_W +: D_W])) + (REAL_LANES[l] ? K_VAL : S_W'(0));

`ifdef XENG_CORR_SAT_EN
    localparam logic signed [S_W-1:0] MAX_V = S_W'((64'sd1 <<< (XENG_WIDTH-1)) - 64'sd1);
    localparam logic signed [S_W-1:0] MIN_V = S_W'(-(64'sd1 <<< (XENG_WIDTH-1)));

    assign sat_c[l] = (sum_c > MAX_V) || (sum_c < MIN_V);
    assign res_c[l*XENG_WIDTH +: XENG_WIDTH] =
      (sum_c > MAX_V) ? MAX_V[XENG_WIDTH-1:0] :
      (sum_c < MIN_V) ? MIN_V[XENG_WIDTH-1:0] :
                        sum_c[XENG_WIDTH-1:0];
`else
    logic [S_W-XENG_WIDTH-1:0] sum_hi_unused_c;

    assign sum_hi_unused_c = sum_c[S_W-1:XENG_WIDTH];
    assign res_c[l*XENG_WIDTH +: XENG_WIDTH] = sum_c[XENG_WIDTH-1:0];
`endif
  end

  // Two-stage data pipeline; dout and bl_idx hold between valid words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= '0;
      s1_vld   <= 1'b0;
      dout     <= '0;
      dout_vld <= 1'b0;
      bl_idx   <= '0;
    end else begin
      s1_vld   <= xeng_vld;
      dout_vld <= s1_vld;
      if (xeng_vld) s1_q <= d_c;
      if (s1_vld) begin
        dout   <= res_c;
        bl_idx <= bl_cnt;
      end
    end
  end

  // Baseline counter advances per output word and restarts on sync
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bl_cnt <= '0;
    end else if (sync) begin
      bl_cnt <= '0;
    end else if (s1_vld) begin
      bl_cnt <= (bl_cnt == BL_W'(N_BLS-1)) ? '0 : bl_cnt + BL_W'(1);
    end
  end

  // Sync delay line matching the data pipeline latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_d   <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      sync_d   <= sync;
      sync_out <= sync_d;
    end
  end

  // Sticky FIFO error flags, cleared by sync
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_ovf <= 1'b0;
      fifo_unf <= 1'b0;
    end else if (sync) begin
      fifo_ovf <= 1'b0;
      fifo_unf <= 1'b0;
    end else begin
      fifo_ovf <= fifo_ovf | fifo_ovf_c;
      fifo_unf <= fifo_unf | fifo_unf_c;
    end
  end

`ifdef XENG_CORR_SAT_EN
  // Sticky saturation flag, set when any lane of an output word clips
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_flag <= 1'b0;
    end else if (sync) begin
      sat_flag <= 1'b0;
    end else if (s1_vld && (|sat_c)) begin
      sat_flag <= 1'b1;
    end
  end
`endif

  // Full flag is only needed inside the FIFO's accept logic
  logic fifo_full_unused_c;
  assign fifo_full_unused_c = fifo_full_c;

endmodule

// File: tb/tb_xeng_corr_apply.sv
// Scoreboard bench for xeng_corr_apply (default parameters).
// Build with XENG_CORR_SAT_EN defined to also exercise saturation.
module tb_xeng_corr_apply;

  localparam int NL  = 8;
  localparam int XW  = 24;
  localparam int CW  = 16;
  localparam int NB  = 544;
  localparam int BLW = 10;
  localparam int KV  = 32768;

  logic              clk = 1'b0;
  logic              rst;
  logic              sync;
  logic [NL*CW-1:0]  corr_din;
  logic              corr_vld;
  logic [NL*XW-1:0]  xeng_din;
  logic              xeng_vld;
  logic [NL*XW-1:0]  dout;
  logic              dout_vld;
  logic [BLW-1:0]    bl_idx;
  logic              sync_out;
  logic              fifo_ovf;
  logic              fifo_unf;
`ifdef XENG_CORR_SAT_EN
  logic              sat_flag;
`endif

  typedef struct packed {
    logic [NL*XW-1:0] d;
    logic [BLW-1:0]   bl;
  } exp_t;

  exp_t             exp_q[$];
  logic [NL*CW-1:0] mq[$];
  int               m_bl;
  bit               m_sat;
  int               n_checks = 0;
  int               n_pass   = 0;

  xeng_corr_apply dut (
    .clk      (clk),
    .rst      (rst),
    .sync     (sync),
    .corr_din (corr_din),
    .corr_vld (corr_vld),
    .xeng_din (xeng_din),
    .xeng_vld (xeng_vld),
    .dout     (dout),
    .dout_vld (dout_vld),
    .bl_idx   (bl_idx),
    .sync_out (sync_out),
    .fifo_ovf (fifo_ovf),
    .fifo_unf (fifo_unf)
`ifdef XENG_CORR_SAT_EN
    ,
    .sat_flag (sat_flag)
`endif
  );

  always #5 clk = ~clk;

  // Reference arithmetic: raw - corr*8, +K on real lanes, wrap or clip to 24 bits
  function automatic logic [NL*XW-1:0] model(input logic [NL*XW-1:0] x, input logic [NL*CW-1:0] c);
    logic [NL*XW-1:0] r;
    logic signed [XW-1:0] xr;
    logic signed [CW-1:0] cr;
    longint v;
    r = '0;
    for (int l = 0; l < NL; l++) begin
      xr = x[l*XW +: XW];
      cr = c[l*CW +: CW];
      v  = longint'(xr) - longint'(cr) * 8 + ((l >= 4) ? KV : 0);
`ifdef XENG_CORR_SAT_EN
      if (v > 64'sd8388607) begin
        v = 64'sd8388607;
        m_sat = 1'b1;
      end else if (v < -64'sd8388608) begin
        v = -64'sd8388608;
        m_sat = 1'b1;
      end
`endif
      r[l*XW +: XW] = v[XW-1:0];
    end
    return r;
  endfunction

  function automatic logic [NL*CW-1:0] rand_corr();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [NL*XW-1:0] rand_raw();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive one cycle of stimulus and advance the model to match
  task automatic step(input logic s, input logic cv, input logic [NL*CW-1:0] c,
                      input logic xv, input logic [NL*XW-1:0] x);
    logic [NL*CW-1:0] cc;
    exp_t e;
    bit   full;
    bit   popped;
    sync = s; corr_vld = cv; corr_din = c; xeng_vld = xv; xeng_din = x;
    if (s) begin
      mq.delete();
      m_bl  = 0;
      m_sat = 1'b0;
    end else begin
      cc     = '0;
      full   = (mq.size() == 32);
      popped = 1'b0;
      if (xv) begin
        if (mq.size() > 0) begin
          cc     = mq.pop_front();
          popped = 1'b1;
        end
        e.d  = model(x, cc);
        e.bl = BLW'(m_bl);
        exp_q.push_back(e);
        m_bl = (m_bl == NB - 1) ? 0 : m_bl + 1;
      end
      if (cv && (!full || popped)) mq.push_back(c);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  // Scoreboard: every valid output word must match the next expected entry
  always @(negedge clk) begin
    exp_t e;
    if (rst !== 1'b1 && dout_vld === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected dout_vld=1 got %h with no expected entry", dout);
      end else begin
        e = exp_q.pop_front();
        if (dout !== e.d || bl_idx !== e.bl)
          $display("FAIL sb_word got dout=%h bl=%0d want dout=%h bl=%0d", dout, bl_idx, e.d, e.bl);
        else
          n_pass++;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; sync = 1'b0; corr_vld = 1'b0; corr_din = '0; xeng_vld = 1'b0; xeng_din = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mq.delete(); exp_q.delete(); m_bl = 0; m_sat = 1'b0;
    idle(10);
    n_checks++; if (dout !== '0) $display("FAIL reset_dout got %h want 0", dout); else n_pass++;
    n_checks++; if (dout_vld !== 1'b0) $display("FAIL reset_dout_vld got %b want 0", dout_vld); else n_pass++;
    n_checks++; if (bl_idx !== '0) $display("FAIL reset_bl_idx got %0d want 0", bl_idx); else n_pass++;
    n_checks++; if (fifo_ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", fifo_ovf); else n_pass++;
    n_checks++; if (fifo_unf !== 1'b0) $display("FAIL reset_unf got %b want 0", fifo_unf); else n_pass++;
    n_checks++; if (sync_out !== 1'b0) $display("FAIL reset_sync_out got %b want 0", sync_out); else n_pass++;
  endtask

  task automatic test_single();
    logic [NL*CW-1:0] c;
    logic [NL*XW-1:0] x;
    c = '0; x = '0;
    c[7*CW +: CW] = 16'd3;
    c[3*CW +: CW] = 16'hFFFE;
    x[7*XW +: XW] = 24'd100;
    x[3*XW +: XW] = 24'd50;
    step(1'b0, 1'b1, c, 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b1, x);
    n_checks++; if (dout_vld !== 1'b0) $display("FAIL single_lat1 got dout_vld=%b want 0", dout_vld); else n_pass++;
    idle(1);
    n_checks++; if (dout_vld !== 1'b1) $display("FAIL single_lat2 got dout_vld=%b want 1", dout_vld); else n_pass++;
    n_checks++; if (dout[7*XW +: XW] !== 24'd32844) $display("FAIL single_re_xx got %0d want 32844", dout[7*XW +: XW]); else n_pass++;
    n_checks++; if (dout[3*XW +: XW] !== 24'd66) $display("FAIL single_im_xx got %0d want 66", dout[3*XW +: XW]); else n_pass++;
    idle(2);
    n_checks++; if (fifo_unf !== 1'b0) $display("FAIL single_unf got %b want 0", fifo_unf); else n_pass++;
  endtask

  task automatic test_stream();
    step(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, rand_corr(), 1'b0, '0);
    for (int i = 0; i < 17; i++) step(1'b0, 1'b0, '0, 1'b1, '0);
    idle(3);
    n_checks++; if (bl_idx !== 10'd16) $display("FAIL stream_last_bl got %0d want 16", bl_idx); else n_pass++;
    n_checks++; if (fifo_ovf !== 1'b0 || fifo_unf !== 1'b0) $display("FAIL stream_flags got ovf=%b unf=%b want 0 0", fifo_ovf, fifo_unf); else n_pass++;
  endtask

  task automatic test_wrap_sync();
    step(1'b1, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b1, rand_corr(), 1'b0, '0);
    for (int i = 0; i < NB + 2; i++) step(1'b0, 1'b1, rand_corr(), 1'b1, rand_raw());
    idle(3);
    n_checks++; if (bl_idx !== 10'd1) $display("FAIL wrap_last_bl got %0d want 1", bl_idx); else n_pass++;
    n_checks++; if (fifo_unf !== 1'b0) $display("FAIL wrap_unf got %b want 0", fifo_unf); else n_pass++;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, rand_corr(), 1'b0, '0);
    idle(3);
    step(1'b1, 1'b0, '0, 1'b0, '0);
    n_checks++; if (sync_out !== 1'b0) $display("FAIL sync_out_d1 got %b want 0", sync_out); else n_pass++;
    idle(1);
    n_checks++; if (sync_out !== 1'b1) $display("FAIL sync_out_d2 got %b want 1", sync_out); else n_pass++;
    idle(1);
    n_checks++; if (sync_out !== 1'b0) $display("FAIL sync_out_d3 got %b want 0", sync_out); else n_pass++;
    step(1'b0, 1'b0, '0, 1'b1, rand_raw());
    idle(3);
    n_checks++; if (bl_idx !== 10'd0) $display("FAIL sync_bl got %0d want 0", bl_idx); else n_pass++;
    n_checks++; if (fifo_unf !== 1'b1) $display("FAIL sync_empty_unf got %b want 1", fifo_unf); else n_pass++;
  endtask

  task automatic test_overflow();
    step(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 33; i++) step(1'b0, 1'b1, rand_corr(), 1'b0, '0);
    idle(1);
    n_checks++; if (fifo_ovf !== 1'b1) $display("FAIL ovf_set got %b want 1", fifo_ovf); else n_pass++;
    for (int i = 0; i < 32; i++) step(1'b0, 1'b0, '0, 1'b1, rand_raw());
    idle(3);
    n_checks++; if (fifo_unf !== 1'b0) $display("FAIL ovf_drain_unf got %b want 0", fifo_unf); else n_pass++;
    step(1'b0, 1'b0, '0, 1'b1, rand_raw());
    idle(3);
    n_checks++; if (fifo_unf !== 1'b1) $display("FAIL ovf_dropped_unf got %b want 1", fifo_unf); else n_pass++;
    step(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, rand_corr(), 1'b0, '0);
    step(1'b0, 1'b1, rand_corr(), 1'b1, rand_raw());
    idle(1);
    n_checks++; if (fifo_ovf !== 1'b0) $display("FAIL full_pushpop_ovf got %b want 0", fifo_ovf); else n_pass++;
    for (int i = 0; i < 32; i++) step(1'b0, 1'b0, '0, 1'b1, rand_raw());
    idle(3);
    n_checks++; if (fifo_unf !== 1'b0) $display("FAIL full_pushpop_unf got %b want 0", fifo_unf); else n_pass++;
  endtask

  task automatic test_underflow();
    logic [NL*XW-1:0] x;
    x = '0;
    x[7*XW +: XW] = 24'd5;
    step(1'b1, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b1, x);
    idle(1);
    n_checks++; if (dout[7*XW +: XW] !== 24'd32773) $display("FAIL unf_re_xx got %0d want 32773", dout[7*XW +: XW]); else n_pass++;
    n_checks++; if (fifo_unf !== 1'b1) $display("FAIL unf_flag got %b want 1", fifo_unf); else n_pass++;
    step(1'b1, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b1, rand_corr(), 1'b1, rand_raw());
    step(1'b0, 1'b0, '0, 1'b1, rand_raw());
    idle(3);
    n_checks++; if (fifo_unf !== 1'b1) $display("FAIL unf_nobypass got %b want 1", fifo_unf); else n_pass++;
  endtask

`ifdef XENG_CORR_SAT_EN
  task automatic test_saturation();
    logic [NL*CW-1:0] c;
    logic [NL*XW-1:0] x;
    c = '0; x = '0;
    c[7*CW +: CW] = 16'hFFFF;
    x[7*XW +: XW] = 24'h7FFFFF;
    step(1'b1, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b1, c, 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b1, x);
    idle(3);
    n_checks++; if (dout[7*XW +: XW] !== 24'h7FFFFF) $display("FAIL sat_re_xx got %h want 7fffff", dout[7*XW +: XW]); else n_pass++;
    n_checks++; if (sat_flag !== 1'b1) $display("FAIL sat_flag_set got %b want 1", sat_flag); else n_pass++;
    step(1'b1, 1'b0, '0, 1'b0, '0);
    n_checks++; if (sat_flag !== 1'b0) $display("FAIL sat_flag_clear got %b want 0", sat_flag); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_wrap_sync();
    test_overflow();
    test_underflow();
`ifdef XENG_CORR_SAT_EN
    test_saturation();
`endif
    idle(5);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL sb_drain got %0d pending want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
